// File: rtl/charli_frame_buf.sv
// rtl/charli_frame_buf.sv - double-buffered 56-LED frame store with PWM dimming and blink
//
// Purpose: the host writes bytes into a shadow frame, then commits to publish
// them to the active frame in one atomic swap. The active frame is gated by a
// 16-step PWM and an optional blink phase, then registered onto data for the
// Charlieplexing driver.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   wr_valid/ready  byte-write handshake; wr_ready low during the swap cycle and reset
//   wr_addr/wr_data shadow byte index (0..6, 7 discarded) and value
//   wr_err          one-cycle pulse after an accepted write to address 7
//   commit          request to copy shadow into active
//   swapped         one-cycle pulse, first cycle the active frame holds the new data
//   blink_en        enable blanking blink, BLINK_DIV cycles per half-period
//   brightness      PWM duty 0..15 (0 off, 15 fully on)
//   data            registered, gated LED frame, bit i = LED i
module charli_frame_buf #(
  parameter int BLINK_DIV = 25000000,
  parameter int PWM_DIV   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        commit,
  input  logic        blink_en,
  input  logic [3:0]  brightness,
  output logic [55:0] data,
  output logic        swapped,
  output logic        wr_err
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(PWM_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {IDLE, SWAP} state_t;

  state_t          state;
  logic [55:0]     shadow;
  logic [55:0]     active;
  logic [PW-1:0]   prescale;
  logic [3:0]      pwm_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            phase_on;
  logic            wr_fire;
  logic            gate;

  // Held low during reset so the host never sees a handshake it cannot complete.
  assign wr_ready = (state == IDLE) && !rst;
  assign wr_fire  = wr_valid && wr_ready;

  // Shadow writes happen on the same edge as a commit is sampled, so a write
  // issued alongside commit is part of the swapped frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      active  <= '0;
      swapped <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_err  <= wr_fire && (wr_addr == 3'd7);
      swapped <= 1'b0;
      if (wr_fire && (wr_addr != 3'd7)) begin
        shadow[{wr_addr, 3'b000} +: 8] <= wr_data;
      end
      case (state)
        IDLE: begin
          if (commit) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          // commit seen here is dropped; exactly one swap per request.
          active  <= shadow;
          swapped <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // PWM step counter advances once per PWM_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      pwm_cnt  <= 4'd0;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
      pwm_cnt  <= pwm_cnt + 4'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // Blink phase starts ON whenever blinking is (re)enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_on  <= !phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Full brightness bypasses the counter so 15 is truly always on.
  assign gate = (brightness == 4'd15) || (pwm_cnt < brightness);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= (gate && phase_on) ? active : 56'b0;
    end
  end

endmodule

// File: tb/tb_charli_frame_buf.sv
// tb/tb_charli_frame_buf.sv - directed self-checking bench for charli_frame_buf
module tb_charli_frame_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit;
  logic        blink_en;
  logic [3:0]  brightness;
  logic [55:0] data;
  logic        swapped;
  logic        wr_err;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [55:0] ONES = {56{1'b1}};
  localparam logic [55:0] FRAME_A = 56'h07060504030201;
  localparam logic [55:0] FRAME_B = 56'h070605FF030201;

  charli_frame_buf #(.BLINK_DIV(4), .PWM_DIV(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
    .blink_en(blink_en), .brightness(brightness), .data(data),
    .swapped(swapped), .wr_err(wr_err)
  );

  always #5 clk = !clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic write_byte(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
    commit = 1'b0; blink_en = 1'b0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    tests_run++;
    if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    tests_run++;
    if (data !== 56'b0) begin tests_failed++; $display("FAIL reset_data got %h want 0", data); end
    tests_run++;
    if (swapped !== 1'b0 || wr_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulses got swapped=%b wr_err=%b want 0 0", swapped, wr_err);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL release_wr_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_basic_frame();
    int n_swp = 0;
    int n_err = 0;
    for (int k = 0; k < 7; k++) begin
      write_byte(3'(k), 8'(k + 1));
      if (wr_err) n_err++;
    end
    @(negedge clk);
    commit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      commit = 1'b0;
      if (swapped) n_swp++;
      if (i == 1) begin
        tests_run++;
        if (data !== 56'b0) begin tests_failed++; $display("FAIL basic_data_early got %h want 0", data); end
      end
      if (i == 2) begin
        tests_run++;
        if (data !== FRAME_A) begin tests_failed++; $display("FAIL basic_data got %h want %h", data, FRAME_A); end
      end
    end
    tests_run++;
    if (n_swp != 1) begin tests_failed++; $display("FAIL basic_swapped_count got %0d want 1", n_swp); end
    tests_run++;
    if (n_err != 0) begin tests_failed++; $display("FAIL basic_wr_err got %0d want 0", n_err); end
  endtask

  task automatic test_write_with_commit();
    int n_low = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'hFF; commit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_valid = 1'b0; commit = 1'b0;
      if (!wr_ready) n_low++;
    end
    tests_run++;
    if (n_low != 1) begin tests_failed++; $display("FAIL same_edge_ready_low got %0d want 1", n_low); end
    tests_run++;
    if (data[31:24] !== 8'hFF) begin tests_failed++; $display("FAIL same_edge_byte3 got %h want ff", data[31:24]); end
    tests_run++;
    if (data !== FRAME_B) begin tests_failed++; $display("FAIL same_edge_frame got %h want %h", data, FRAME_B); end
  endtask

  task automatic test_bad_addr();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 8'hAA;
    @(negedge clk);
    wr_valid = 1'b0;
    tests_run++;
    if (wr_err !== 1'b1) begin tests_failed++; $display("FAIL bad_addr_err got %b want 1", wr_err); end
    @(negedge clk);
    tests_run++;
    if (wr_err !== 1'b0) begin tests_failed++; $display("FAIL bad_addr_err_width got %b want 0", wr_err); end
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (data !== FRAME_B) begin tests_failed++; $display("FAIL bad_addr_frame got %h want %h", data, FRAME_B); end
  endtask

  task automatic test_back_to_back();
    int n_low = 0;
    int n_swp = 0;
    for (int k = 0; k < 7; k++) write_byte(3'(k), 8'hFF);
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    // still high while in SWAP; must not queue a second swap
    if (!wr_ready) n_low++;
    if (swapped) n_swp++;
    @(negedge clk);
    commit = 1'b0;
    if (!wr_ready) n_low++;
    if (swapped) n_swp++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!wr_ready) n_low++;
      if (swapped) n_swp++;
    end
    tests_run++;
    if (n_low != 1) begin tests_failed++; $display("FAIL hold_commit_ready_low got %0d want 1", n_low); end
    tests_run++;
    if (n_swp != 1) begin tests_failed++; $display("FAIL hold_commit_swapped got %0d want 1", n_swp); end
    tests_run++;
    if (data !== ONES) begin tests_failed++; $display("FAIL ones_frame got %h want all ones", data); end
  endtask

  task automatic test_pwm();
    int n_on = 0;
    int n_bad = 0;
    @(negedge clk);
    brightness = 4'd4;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (data === ONES) n_on++;
      else if (data !== 56'b0) n_bad++;
    end
    tests_run++;
    if (n_on != 4) begin tests_failed++; $display("FAIL pwm4_on_count got %0d want 4", n_on); end
    tests_run++;
    if (n_bad != 0) begin tests_failed++; $display("FAIL pwm4_partial got %0d want 0", n_bad); end
    brightness = 4'd0;
    @(negedge clk);
    n_on = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data !== 56'b0) n_on++;
    end
    tests_run++;
    if (n_on != 0) begin tests_failed++; $display("FAIL pwm0_nonzero got %0d want 0", n_on); end
    brightness = 4'd15;
    @(negedge clk);
    n_on = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data === ONES) n_on++;
    end
    tests_run++;
    if (n_on != 20) begin tests_failed++; $display("FAIL pwm15_on_count got %0d want 20", n_on); end
  endtask

  task automatic test_blink();
    logic [55:0] exp;
    int n_on = 0;
    @(negedge clk);
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = (((i / 4) % 2) == 0) ? ONES : 56'b0;
      tests_run++;
      if (data !== exp) begin
        tests_failed++; $display("FAIL blink_sample_%0d got %h want %h", i, data, exp);
      end
    end
    blink_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (data === ONES) n_on++;
    end
    tests_run++;
    if (n_on != 12) begin tests_failed++; $display("FAIL blink_off_steady got %0d want 12", n_on); end
  endtask

  task automatic test_rst_in_swap();
    int n_swp = 0;
    int n_nz = 0;
    int n_busy = 0;
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    tests_run++;
    if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL pre_abort_in_swap got %b want 0", wr_ready); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (data !== 56'b0) begin tests_failed++; $display("FAIL async_rst_data got %h want 0", data); end
    @(negedge clk);
    tests_run++;
    if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_ready got %b want 0", wr_ready); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (swapped) n_swp++;
      if (data !== 56'b0) n_nz++;
      if (!wr_ready) n_busy++;
    end
    tests_run++;
    if (n_swp != 0) begin tests_failed++; $display("FAIL abort_swapped got %0d want 0", n_swp); end
    tests_run++;
    if (n_nz != 0) begin tests_failed++; $display("FAIL abort_data got %0d nonzero want 0", n_nz); end
    tests_run++;
    if (n_busy != 0) begin tests_failed++; $display("FAIL abort_wr_ready got %0d low want 0", n_busy); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_write_with_commit();
    test_bad_addr();
    test_back_to_back();
    test_pwm();
    test_blink();
    test_rst_in_swap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/charli_frame_buf.md
CHARLI_FRAME_BUF -- requirements
Module: charli_frame_buf

Interface
REQ-001 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (>=2).
REQ-002 Parameter PWM_DIV, default 64, clk cycles per PWM step (>=1).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_valid  input  1  byte-write request.
REQ-006 wr_ready  output  1  block accepts write this cycle.
REQ-007 wr_addr  input  3  shadow byte index 0..6; 7 is invalid.
REQ-008 wr_data  input  8  byte value; byte k maps to frame bits [8k+7:8k].
REQ-009 commit  input  1  single-cycle request to publish shadow to active frame.
REQ-010 blink_en  input  1  enables blanking blink.
REQ-011 brightness  input  4  PWM duty, 0 = off, 15 = fully on.
REQ-012 data  output  56  registered LED frame to the Charlieplexing driver, bit i = LED i.
REQ-013 swapped  output  1  one-cycle pulse: active frame just reloaded.
REQ-014 wr_err  output  1  one-cycle pulse: write to wr_addr 7 was accepted and discarded.

Function
REQ-015 Storage SHALL be double-buffered: 56-bit shadow (write side), 56-bit active (display side).
REQ-016 A write SHALL occur on an edge where wr_valid && wr_ready; shadow byte wr_addr <= wr_data, other bytes unchanged.
REQ-017 wr_addr 7 write SHALL leave shadow unchanged and pulse wr_err in the following cycle.
REQ-018 FSM states SHALL be IDLE and SWAP; reset state IDLE.
REQ-019 IDLE: wr_ready = 1; commit sampled high -> SWAP next cycle.
REQ-020 SWAP: wr_ready = 0; active <= shadow at the edge leaving SWAP; SWAP -> IDLE unconditionally (one cycle).
REQ-021 commit asserted in SWAP SHALL be ignored (no queued second swap).
REQ-022 Write and commit on the same IDLE edge: write SHALL land in shadow first and be included in the swap.
REQ-023 swapped SHALL be high the cycle after SWAP (the first cycle active holds the new frame).
REQ-024 data SHALL update the cycle after active changes (1-cycle register): commit edge N -> active valid after edge N+1 -> data valid after edge N+2.
REQ-025 PWM: 4-bit pwm_cnt SHALL increment (wrapping 15->0) once every PWM_DIV clk cycles via a prescaler.
REQ-026 PWM gate = (brightness == 15) || (pwm_cnt < brightness); brightness 0 SHALL give gate always 0.
REQ-027 Blink: when blink_en, phase SHALL toggle every BLINK_DIV cycles, starting in ON phase; when blink_en low, phase forced ON and blink counter held at 0.
REQ-028 data SHALL be registered as active when (gate && phase ON), else 56'b0.
REQ-029 brightness and blink_en changes SHALL take effect on the next data register update, no resync of frames.

Reset
REQ-030 On rst: shadow = 0, active = 0, data = 0, FSM = IDLE, wr_ready = 1 after release, swapped = 0, wr_err = 0, pwm_cnt = 0, prescaler = 0, blink counter = 0, phase ON.
REQ-031 rst asserted in SWAP SHALL abort the swap; active stays 0, no swapped pulse.
REQ-032 wr_ready SHALL be 0 while rst is high.

Verification (BLINK_DIV=4, PWM_DIV=1 unless stated)
REQ-033 Write bytes 0..6 = 0x01..0x07, brightness 15, commit -> data = 56'h07060504030201 two cycles after commit edge, swapped pulses once.
REQ-034 Write addr 3 = 0xFF on same edge as commit, brightness 15 -> data[31:24] = 8'hFF after swap; wr_ready low exactly one cycle.
REQ-035 Write addr 7 = 0xAA -> wr_err one-cycle pulse, shadow unchanged, subsequent commit shows prior frame.
REQ-036 Active all-ones, brightness 4 -> data all-ones exactly 4 of every 16 cycles; brightness 0 -> data = 0 continuously.
REQ-037 Active all-ones, brightness 15, blink_en = 1 -> data alternates 4 cycles all-ones / 4 cycles zero; blink_en = 0 -> all-ones steadily.
REQ-038 Commit, then rst asserted during SWAP -> data = 0, swapped never pulses, wr_ready returns 1 after release.
